booth_seq_ctrl: RTL and testbench



---
 rtl/booth_seq_ctrl_if.sv | 22 ++
 rtl/booth_seq_ctrl.sv | 102 ++++++++++
 tb/tb_booth_seq_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/booth_seq_ctrl_if.sv
// Handshake and operand/result bundle for the Booth multiplier controller.
// Master requests a product; slave computes it and pulses done.
interface booth_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;

  modport master (
    output start, op_a, op_b,
    input  product, busy, done
  );

  modport slave (
    input  start, op_a, op_b,
    output product, busy, done
  );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller.
// One Booth iteration per clock; registered signed product with done pulse.
module booth_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  booth_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q1_q, q1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH:0]       sum;

  logic st_idle, st_calc, st_done;

  assign st_idle = (state_q == S_IDLE);
  assign st_calc = (state_q == S_CALC);
  assign st_done = (state_q == S_DONE);

  // Booth add/sub select, arithmetic shift and sequencing
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    sum       = acc_q;

    unique case ({q_q[0], q1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase

    unique case (1'b1)
      st_idle: begin
        if (bus.start) begin
          m_d     = {bus.op_a[WIDTH-1], bus.op_a};
          acc_d   = '0;
          q_d     = bus.op_b;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = S_CALC;
        end
      end
      st_calc: begin
        acc_d = {sum[WIDTH], sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          product_d = {acc_d[WIDTH-1:0], q_d};
          state_d   = S_DONE;
        end
      end
      st_done: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = !st_idle;
  assign bus.done    = st_done;
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl.
// Hand-computed products, latency, busy/done timing and reset.
module tb_booth_seq_ctrl;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  booth_seq_ctrl_if #(.WIDTH(8)) bus ();

  booth_seq_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input string tag,
                         input logic [7:0] a,
                         input logic [7:0] b,
                         input logic [15:0] exp);
    int lat;
    int nbusy;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    tick();
    bus.start = 1'b0;
    bus.op_a  = ~a;
    bus.op_b  = ~b;
    lat   = 0;
    nbusy = bus.busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.busy) nbusy++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, 8);
    check({tag, "_busy"}, nbusy, 9);
    check({tag, "_prod"}, {16'd0, bus.product}, {16'd0, exp});
    tick();
    check({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 0);
  endtask

  initial begin
    int ndone;
    int t1;
    int t2;
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    tick();
    tick();
    check("rst_prod", {16'd0, bus.product}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    run_mul("m7x3", 8'd7, 8'd3, 16'h0015);
    run_mul("mn5x3", 8'hFB, 8'h03, 16'hFFF1);
    run_mul("m127xn128", 8'h7F, 8'h80, 16'hC080);
    run_mul("mn128sq", 8'h80, 8'h80, 16'h4000);
    run_mul("m0xn1", 8'h00, 8'hFF, 16'h0000);

    // start while busy is ignored
    bus.start = 1'b1;
    bus.op_a  = 8'd7;
    bus.op_b  = 8'd3;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        bus.start = 1'b1;
        bus.op_a  = 8'd2;
        bus.op_b  = 8'd2;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      if (bus.done) ndone++;
    end
    check("sib_ndone", ndone, 1);
    check("sib_prod", {16'd0, bus.product}, 32'h15);
    check("sib_busy", {31'd0, bus.busy}, 0);

    // held start: back-to-back products
    bus.start = 1'b1;
    bus.op_a  = 8'd5;
    bus.op_b  = 8'd3;
    tick();
    t1 = 0;
    t2 = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (bus.done) begin
        if (t1 == 0) t1 = k;
        else if (t2 == 0) t2 = k;
      end
      if (t2 != 0) bus.start = 1'b0;
    end
    check("hold_t1", t1, 8);
    check("hold_gap", t2 - t1, 10);
    check("hold_prod", {16'd0, bus.product}, 32'h0F);
    check("hold_busy", {31'd0, bus.busy}, 0);

    // reset mid-operation
    bus.start = 1'b1;
    bus.op_a  = 8'd7;
    bus.op_b  = 8'd3;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    #2;
    rst = 1'b0;
    #1;
    check("amid_busy", {31'd0, bus.busy}, 0);
    check("amid_done", {31'd0, bus.done}, 0);
    check("amid_prod", {16'd0, bus.product}, 0);
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("amid_nodone", ndone, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("amid_post", {16'd0, bus.product}, 0);
    run_mul("m6x6", 8'd6, 8'd6, 16'h0024);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
